// File: rtl/demux_pkg.sv
// ============================================================================
// Module : demux_pkg
// Brief  : Shared constants, select type and select helpers for the 1-to-5
//          handshaked demultiplexer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package demux_pkg;

    localparam int NUM_OUT = 5;
    localparam int SEL_W   = 3;

    typedef logic [SEL_W-1:0] sel_t;

    localparam sel_t SEL_BCAST     = 3'd7;
    localparam sel_t SEL_MAX_LEGAL = 3'd4;

    function automatic logic sel_is_legal(input sel_t s);
        return (s <= SEL_MAX_LEGAL);
    endfunction

endpackage

`default_nettype wire

// File: rtl/demux_out_slot.sv
// ============================================================================
// Module : demux_out_slot
// Brief  : One-entry registered output slot with valid/ready drain and a
//          "frees this cycle" indication used by the upstream select logic.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module demux_out_slot #(
    parameter int size = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic [size-1:0] data_i,
    input  logic            ready_i,
    output logic            valid_o,
    output logic [size-1:0] data_o,
    output logic            frees_o
);

    logic            valid_q, valid_d;
    logic [size-1:0] data_q,  data_d;

    // A load wins over a drain so a same-cycle drain+load keeps the slot full.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign frees_o = !valid_q || ready_i;

endmodule

`default_nettype wire

// File: rtl/demux_1to5_32b_hs.sv
// ============================================================================
// Module : demux_1to5_32b_hs
// Brief  : Handshaked 1-to-5 demultiplexer with per-port one-entry slots and
//          a sticky illegal-select flag. Optional broadcast on select=7 when
//          DEMUX_BCAST_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module demux_1to5_32b_hs
    import demux_pkg::*;
#(
    parameter int size = 32
) (
    input  logic            CGRA_Clock,
    input  logic            CGRA_Reset_n,
    input  logic [size-1:0] in_data,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      select,
    output logic [size-1:0] out0_data,
    output logic            out0_valid,
    input  logic            out0_ready,
    output logic [size-1:0] out1_data,
    output logic            out1_valid,
    input  logic            out1_ready,
    output logic [size-1:0] out2_data,
    output logic            out2_valid,
    input  logic            out2_ready,
    output logic [size-1:0] out3_data,
    output logic            out3_valid,
    input  logic            out3_ready,
    output logic [size-1:0] out4_data,
    output logic            out4_valid,
    input  logic            out4_ready,
    output logic            sel_err
);

    sel_t               w_sel;
    logic               w_legal;
    logic               w_bcast;
    logic               w_in_ready;
    logic               w_xfer;
    logic [NUM_OUT-1:0] w_hit;
    logic [NUM_OUT-1:0] w_frees;
    logic [NUM_OUT-1:0] w_load;
    logic [NUM_OUT-1:0] w_ready;
    logic [NUM_OUT-1:0] w_valid;
    logic [size-1:0]    w_data [NUM_OUT];
    logic               sel_err_q, sel_err_d;

    assign w_sel   = select;
    assign w_legal = sel_is_legal(w_sel);
`ifdef DEMUX_BCAST_EN
    assign w_bcast = (w_sel == SEL_BCAST);
`else
    assign w_bcast = 1'b0;
`endif

    assign w_ready = {out4_ready, out3_ready, out2_ready, out1_ready, out0_ready};

    // in_ready looks only at select and the slots' frees terms, never at data.
    always_comb begin
        w_in_ready = 1'b1;
        if (w_legal) begin
            w_in_ready = |(w_hit & w_frees);
        end else if (w_bcast) begin
            w_in_ready = &w_frees;
        end
    end

    assign w_xfer   = in_valid && w_in_ready;
    assign in_ready = w_in_ready;

    generate
        for (genvar i = 0; i < NUM_OUT; i++) begin : g_slot
            assign w_hit[i]  = (w_sel == sel_t'(i));
            assign w_load[i] = w_xfer && (w_bcast || (w_legal && w_hit[i]));

            demux_out_slot #(
                .size (size)
            ) u_slot (
                .clk     (CGRA_Clock),
                .rst_n   (CGRA_Reset_n),
                .load_i  (w_load[i]),
                .data_i  (in_data),
                .ready_i (w_ready[i]),
                .valid_o (w_valid[i]),
                .data_o  (w_data[i]),
                .frees_o (w_frees[i])
            );
        end
    endgenerate

    // Illegal selects are accepted and dropped; the flag records that it happened.
    assign sel_err_d = sel_err_q || (w_xfer && !w_legal && !w_bcast);

    always_ff @(posedge CGRA_Clock or negedge CGRA_Reset_n) begin
        if (!CGRA_Reset_n) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

    assign sel_err    = sel_err_q;
    assign out0_data  = w_data[0];
    assign out1_data  = w_data[1];
    assign out2_data  = w_data[2];
    assign out3_data  = w_data[3];
    assign out4_data  = w_data[4];
    assign out0_valid = w_valid[0];
    assign out1_valid = w_valid[1];
    assign out2_valid = w_valid[2];
    assign out3_valid = w_valid[3];
    assign out4_valid = w_valid[4];

endmodule

`default_nettype wire

// File: tb/tb_demux_1to5_32b_hs.sv
// ============================================================================
// Module : tb_demux_1to5_32b_hs
// Brief  : Self-checking bench: slot-level reference model compared every
//          cycle, plus directed vectors with literal expectations.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_demux_1to5_32b_hs;

    logic        clk;
    logic        rst_n;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  sel;
    logic [31:0] od [5];
    logic [4:0]  ov;
    logic [4:0]  ordy;
    logic        sel_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: what each slot holds, and the sticky error.
    logic        mv [5];
    logic [31:0] md [5];
    logic        merr;

    demux_1to5_32b_hs #(.size(32)) dut (
        .CGRA_Clock   (clk),
        .CGRA_Reset_n (rst_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .select       (sel),
        .out0_data    (od[0]), .out0_valid (ov[0]), .out0_ready (ordy[0]),
        .out1_data    (od[1]), .out1_valid (ov[1]), .out1_ready (ordy[1]),
        .out2_data    (od[2]), .out2_valid (ov[2]), .out2_ready (ordy[2]),
        .out3_data    (od[3]), .out3_valid (ov[3]), .out3_ready (ordy[3]),
        .out4_data    (od[4]), .out4_valid (ov[4]), .out4_ready (ordy[4]),
        .sel_err      (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Acceptance rule: a word may enter when every slot it targets can free up.
    function automatic logic m_ready();
        logic all_free;
        all_free = 1'b1;
        for (int k = 0; k < 5; k++) all_free &= (!mv[k] || ordy[k]);
        if (sel <= 3'd4) return !mv[sel] || ordy[sel];
`ifdef DEMUX_BCAST_EN
        if (sel == 3'd7) return all_free;
`endif
        return 1'b1;
    endfunction

    function automatic logic m_bcast();
`ifdef DEMUX_BCAST_EN
        return (sel == 3'd7);
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 5; k++) begin
                mv[k] = 1'b0;
                md[k] = '0;
            end
            merr = 1'b0;
        end else begin
            logic xfer, bc;
            xfer = in_valid && m_ready();
            bc   = m_bcast();
            for (int k = 0; k < 5; k++) begin
                if (xfer && (bc || sel == 3'(k))) begin
                    mv[k] = 1'b1;
                    md[k] = in_data;
                end else if (ordy[k]) begin
                    mv[k] = 1'b0;
                end
            end
            if (xfer && sel > 3'd4 && !bc) merr = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("model in_ready", 32'(in_ready), 32'(m_ready()));
            chk("model sel_err", 32'(sel_err), 32'(merr));
            for (int k = 0; k < 5; k++) begin
                chk($sformatf("model out%0d_valid", k), 32'(ov[k]), 32'(mv[k]));
                chk($sformatf("model out%0d_data", k), od[k], md[k]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [31:0] d, input logic [2:0] s);
        in_data  = d;
        sel      = s;
        in_valid = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_data  = '0;
        in_valid = 1'b0;
        sel      = '0;
        ordy     = 5'b11111;
        #1;
        chk("reset valids", 32'(ov), 32'h0);
        chk("reset sel_err", 32'(sel_err), 32'h0);
        chk("reset out3_data", od[3], 32'h0);
        step(); step();
        rst_n = 1'b1;
        step();

        // Continuous stream, all consumers ready.
        for (int k = 0; k < 5; k++) begin
            send(32'hA0 + 32'(k), 3'(k));
            #1;
            chk("stream in_ready", 32'(in_ready), 32'h1);
            step();
            chk("stream valid", 32'(ov[k]), 32'h1);
            chk("stream data", od[k], 32'hA0 + 32'(k));
        end
        in_valid = 1'b0;
        step();
        chk("stream drained", 32'(ov), 32'h0);

        // Backpressure on port 2.
        ordy = 5'b11011;
        send(32'h11, 3'd2);
        step();
        send(32'h22, 3'd2);
        #1;
        chk("bp in_ready low", 32'(in_ready), 32'h0);
        step();
        chk("bp held data", od[2], 32'h11);
        step();
        chk("bp still held", od[2], 32'h11);
        ordy = 5'b11111;
        #1;
        chk("bp in_ready high", 32'(in_ready), 32'h1);
        step();
        chk("bp 0x22 lands", od[2], 32'h22);
        send(32'h33, 3'd0);
        step();
        chk("bp 0x33 lands", od[0], 32'h33);

        // Same-cycle drain and load on slot 3.
        send(32'h44, 3'd3);
        step();
        send(32'h55, 3'd3);
        #1;
        chk("s3 in_ready", 32'(in_ready), 32'h1);
        step();
        chk("s3 no bubble", 32'(ov[3]), 32'h1);
        chk("s3 new data", od[3], 32'h55);

        // Illegal select: accepted, dropped, flagged.
        send(32'hDEAD, 3'd6);
        #1;
        chk("illegal in_ready", 32'(in_ready), 32'h1);
        step();
        chk("illegal no valid", 32'(ov), 32'h0);
        chk("illegal sel_err", 32'(sel_err), 32'h1);
        send(32'h66, 3'd1);
        step();
        in_valid = 1'b0;
        chk("sticky sel_err", 32'(sel_err), 32'h1);
        chk("legal after err", od[1], 32'h66);

        // Mid-stream reset with full slots.
        ordy = 5'b00000;
        send(32'h90, 3'd0);
        step();
        send(32'h91, 3'd1);
        step();
        chk("prefill valids", 32'(ov), 32'h3);
        send(32'h92, 3'd2);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async reset valids", 32'(ov), 32'h0);
        chk("async reset sel_err", 32'(sel_err), 32'h0);
        in_valid = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();

        // Broadcast / select 7.
        ordy = 5'b01111;
        send(32'h77, 3'd4);
        step();
        send(32'hBEEF, 3'd7);
        #1;
`ifdef DEMUX_BCAST_EN
        chk("bcast blocked", 32'(in_ready), 32'h0);
        step();
        chk("bcast slot4 held", od[4], 32'h77);
        ordy = 5'b11111;
        #1;
        chk("bcast in_ready", 32'(in_ready), 32'h1);
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) chk("bcast data", od[k], 32'hBEEF);
        chk("bcast valids", 32'(ov), 32'h1F);
        chk("bcast sel_err", 32'(sel_err), 32'h0);
`else
        chk("sel7 in_ready", 32'(in_ready), 32'h1);
        step();
        in_valid = 1'b0;
        chk("sel7 sel_err", 32'(sel_err), 32'h1);
        chk("sel7 slot4 kept", od[4], 32'h77);
        chk("sel7 valids", 32'(ov), 32'h10);
`endif
        step(); step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
